// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-stage types: widths, reset PC, FSM encoding and buffer entry layout.
// Pure declarations, no logic.
package ifetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Two-entry {pc, inst} fetch buffer; head visible the cycle after its push.
// Push while full is dropped unless a pop frees the slot in the same cycle; flush wins over both.
module fetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_data,
    output logic [1:0]   count
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && ((count != FULL_COUNT) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Sequential instruction fetch into a two-entry buffer with redirect and sticky misalignment fault.
// First instruction visible two cycles after reset; decode stall (dec_ready=0) holds pc once the buffer is full.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] imem_address,
    output logic            imem_read_write,
    input  logic [ILEN-1:0] imem_data_out,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            dec_ready,
    output logic            dec_valid,
    output logic [ILEN-1:0] dec_inst,
    output logic [XLEN-1:0] dec_pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            push;
    logic            pop;
    logic            flush;
    logic            redirect_take;
    logic            misaligned;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = (redirect_take && misaligned) ? ST_FAULT : ST_FETCH;
            ST_FETCH: if (redirect_take && misaligned) state_next = ST_FAULT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_BOOT;
        endcase
    end

    // Any redirect suppresses both buffer ports for the cycle; FAULT ignores redirects entirely.
    always_comb begin
        misaligned    = is_misaligned(redirect_target[1:0]);
        redirect_take = redirect_valid && (state != ST_FAULT);
        flush         = redirect_take;
        dec_valid     = (count != 2'd0) && !redirect_valid && (state != ST_FAULT);
        pop           = dec_valid && dec_ready;
        push          = (state == ST_FETCH) && !redirect_valid && ((count != FULL_COUNT) || pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_take && !misaligned) begin
            pc <= redirect_target;
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_take && misaligned) begin
            fetch_fault <= 1'b1;
            fault_pc    <= redirect_target;
        end
    end

    assign push_entry = '{pc: pc, inst: imem_data_out};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_data (head),
        .count     (count)
    );

    assign imem_address    = pc;
    assign imem_read_write = 1'b0;
    assign dec_inst        = head.inst;
    assign dec_pc          = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based fetch model checked every cycle, plus pinned literal scenarios.
module tb_ifetch_unit;

    localparam logic [31:0] RPC = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_out;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: program counter, ordered list of buffered {pc, inst}, boot/fault flags.
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_fault;
    logic [31:0] m_fault_pc;
    logic [63:0] mq[$];

    ifetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_read_write (imem_read_write),
        .imem_data_out   (imem_data_out),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec_ready       (dec_ready),
        .dec_valid       (dec_valid),
        .dec_inst        (dec_inst),
        .dec_pc          (dec_pc),
        .fetch_fault     (fetch_fault),
        .fault_pc        (fault_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0100_0000) return 32'h0000_0013;
        if (a == 32'h0100_0004) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_data_out = mem_word(imem_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = RPC;
        m_boot     = 1'b1;
        m_fault    = 1'b0;
        m_fault_pc = 32'h0;
        mq.delete();
    endtask

    task automatic model_step();
        int n;
        bit popped;
        if (m_fault) return;
        if (redirect_valid) begin
            mq.delete();
            m_boot = 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                m_fault    = 1'b1;
                m_fault_pc = redirect_target;
            end else begin
                m_pc = redirect_target;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            n      = mq.size();
            popped = (n != 0) && dec_ready;
            if (popped) void'(mq.pop_front());
            if (n < 2 || popped) begin
                mq.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        logic        exp_valid;
        logic [63:0] head;
        exp_valid = !m_fault && (mq.size() != 0) && !redirect_valid;
        check("dec_valid", {31'b0, dec_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            head = mq[0];
            check("dec_pc", dec_pc, head[63:32]);
            check("dec_inst", dec_inst, head[31:0]);
        end
        check("imem_address", imem_address, m_pc);
        check("imem_read_write", {31'b0, imem_read_write}, 32'h0);
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        check("fault_pc", fault_pc, m_fault_pc);
    endtask

    // Compare on the falling edge, advance the model on the rising edge, return just after it.
    task automatic cycle();
        @(negedge clock);
        compare();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic cycles(input int n, input logic rdy);
        dec_ready = rdy;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_inst", dec_inst, 32'h0);
        check("rst_imem_address", imem_address, RPC);
        check("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic random_phase(input int n, input bit allow_misaligned);
        logic [31:0] tmp;
        for (int i = 0; i < n; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                tmp = $urandom();
                redirect_valid = 1'b1;
                if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFF8;
                else if (allow_misaligned)     redirect_target = tmp;
                else                           redirect_target = tmp & 32'hFFFF_FFFC;
            end else begin
                redirect_valid = 1'b0;
            end
            cycle();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Boot: BOOT cycle, push cycle, then head visible.
        dec_ready = 1'b1;
        cycle();
        check("boot_nothing_yet", {31'b0, dec_valid}, 32'h0);
        cycle();
        check("boot_first_valid", {31'b0, dec_valid}, 32'h1);
        check("boot_first_pc", dec_pc, 32'h0100_0000);
        check("boot_first_inst", dec_inst, 32'h0000_0013);
        cycle();
        check("boot_second_pc", dec_pc, 32'h0100_0004);
        check("boot_second_inst", dec_inst, 32'h0010_0093);
        cycles(4, 1'b1);

        // Backpressure: buffer saturates, pc parks two words ahead.
        do_reset();
        cycles(2, 1'b0);
        cycles(5, 1'b0);
        check("bp_pc_hold", imem_address, 32'h0100_0008);
        check("bp_head_pc", dec_pc, 32'h0100_0000);
        cycle();
        dec_ready = 1'b1;
        cycle();
        check("bp_resume_pc", dec_pc, 32'h0100_0004);
        cycles(6, 1'b1);

        // Redirect with a full buffer.
        cycles(3, 1'b0);
        dec_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0100_0040;
        #1;
        check("redir_valid_low", {31'b0, dec_valid}, 32'h0);
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("redir_flushed", {31'b0, dec_valid}, 32'h0);
        check("redir_pc", imem_address, 32'h0100_0040);
        cycle();
        check("redir_head_pc", dec_pc, 32'h0100_0040);
        cycles(4, 1'b1);

        // Wrap of pc past the top of the address space.
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("wrap_head_top", dec_pc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_head_zero", dec_pc, 32'h0000_0000);
        check("wrap_pc", imem_address, 32'h0000_0004);

        random_phase(400, 1'b0);

        // Misaligned redirect: sticky fault, later redirects ignored.
        dec_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0100_0042;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("fault_flag", {31'b0, fetch_fault}, 32'h1);
        check("fault_pc", fault_pc, 32'h0100_0042);
        check("fault_no_valid", {31'b0, dec_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_target = 32'h0100_0080;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("fault_pc_frozen", fault_pc, 32'h0100_0042);
        check("fault_still_no_valid", {31'b0, dec_valid}, 32'h0);
        random_phase(60, 1'b1);

        // Asynchronous reset pulse between edges with a full buffer.
        do_reset();
        cycles(6, 1'b0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("areset_dec_valid", {31'b0, dec_valid}, 32'h0);
        check("areset_imem_address", imem_address, RPC);
        check("areset_dec_pc", dec_pc, 32'h0);
        check("areset_fault", {31'b0, fetch_fault}, 32'h0);
        #1;
        reset = 1'b0;
        cycles(2, 1'b1);
        check("areset_reboot_pc", dec_pc, RPC);
        cycles(5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h01000000, the first fetch address after reset (instruction memory base).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 2, the number of fetch-buffer entries; only the value 2 is supported.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports, in this order:
  - clock  input  1  rising-edge clock for all state.
  - reset  input  1  asynchronous, active-high reset.
  - imem_address  output  32  byte address of the word presented to instruction memory.
  - imem_read_write  output  1  memory write enable; tied to 0.
  - imem_data_out  input  32  little-endian instruction word, valid in the same cycle as imem_address.
  - redirect_valid  input  1  branch/jump redirect request.
  - redirect_target  input  32  new PC for the redirect.
  - dec_ready  input  1  decode stage accepts an instruction this cycle.
  - dec_valid  output  1  dec_inst/dec_pc hold a valid instruction.
  - dec_inst  output  32  instruction at the buffer head.
  - dec_pc  output  32  PC of dec_inst.
  - fetch_fault  output  1  sticky misaligned-redirect flag.
  - fault_pc  output  32  the offending redirect_target.

Function
REQ-005 SHALL drive imem_address = pc combinationally and imem_read_write = 0 at all times.
REQ-006 States: BOOT, FETCH, FAULT.
  - Reset enters BOOT.
  - BOOT -> FETCH after exactly one clock, with no push during BOOT.
  - FETCH -> FAULT on a misaligned redirect.
  - FAULT is left only by reset.
REQ-007 In FETCH, when no redirect is active, push {pc, imem_data_out} and set pc <= pc + 4 when count < 2 or a pop occurs in the same cycle; otherwise hold pc.
REQ-008 Pop occurs when dec_valid && dec_ready; dec_valid = (count != 0) && !redirect_valid; the buffer is FIFO ordered.
REQ-009 Simultaneous push and pop at count 1 or 2 leaves count unchanged; the head advances to the next entry.
REQ-010 pc + 4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000) with no flag.
REQ-011 Aligned redirect (redirect_target[1:0] == 2'b00), in BOOT or FETCH:
  - Flush all buffer entries (count <= 0).
  - Set pc <= redirect_target.
  - No push and no pop that cycle.
  - A redirect in BOOT also moves the state to FETCH.
  - The first push from the new target occurs the following cycle.
REQ-012 Misaligned redirect (redirect_target[1:0] != 0):
  - Flush the buffer.
  - Set fetch_fault <= 1 and fault_pc <= redirect_target.
  - Enter FAULT; pc is held.
REQ-013 In FAULT:
  - dec_valid = 0.
  - No pushes.
  - redirect_valid is ignored.
  - fault_pc is frozen.
REQ-014 dec_inst/dec_pc SHALL equal the head entry storage; when count == 0 they hold their last value and are don't-care.
REQ-015 First fetch latency: the instruction at RESET_PC is visible on dec_valid in the second cycle after reset deasserts (BOOT cycle, then push cycle, then visible).

Reset
REQ-016 Asynchronous reset SHALL set:
  - pc = RESET_PC, so imem_address = RESET_PC.
  - count = 0, dec_valid = 0.
  - Buffer storage = 0, so dec_inst = 0 and dec_pc = 0.
  - fetch_fault = 0, fault_pc = 0, state = BOOT.
REQ-017 Reset asserted mid-operation SHALL discard buffered entries and any pending redirect immediately, without waiting for a clock edge.

Structure
REQ-018 A shared package/define header SHALL hold the state encodings, RESET_PC, and the instruction/address widths (32).
REQ-019 The two-entry buffer SHALL be a sub-module fetch_fifo with these ports:
  - push, push_data (64 bits, {pc, inst}).
  - pop, flush.
  - head_data, count.
  - clock, reset.

Verification
REQ-020 Boot: release reset with memory words 0x00000013 at 0x01000000 and 0x00100093 at 0x01000004, dec_ready=1 -> dec_pc 0x01000000 then 0x01000004 on consecutive cycles, with correct dec_inst.
REQ-021 Backpressure: dec_ready=0 for 5 cycles after boot -> count saturates at 2, pc holds at 0x01000008, no entry is lost or duplicated when dec_ready returns to 1.
REQ-022 Redirect: redirect_valid=1 with target 0x01000040 while count=2 -> dec_valid=0 that cycle, buffer flushed, next dec_pc is 0x01000040.
REQ-023 Fault: redirect target 0x01000042 -> fetch_fault=1, fault_pc=0x01000042, dec_valid stays 0; a later aligned redirect is ignored.
REQ-024 Wrap: redirect to 0xFFFFFFFC -> dec_pc sequence 0xFFFFFFFC, 0x00000000.
REQ-025 Async reset pulse between clock edges with count=2 -> dec_valid=0 and imem_address=0x01000000 before the next rising edge.
